// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory / write-back stage fed directly by the ID/EX register.
//   - Holds the DEPTH x DATA_W data memory and the MEM/WB output register.
//   - After reset, a clear sequence zero-fills the memory (busy=1) before
//     the stage accepts any pipeline traffic.
//   - Flags load-use hazards against the instruction currently in ID.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   en                     stage enable (shared with ID/EX)
//   ireg_write_addr/_en    destination register / write request from ID/EX
//   ireg_read_data1        write-back value for non-load instructions
//   imem_to_reg            select memory read data for write-back
//   imem_write_en          store request
//   idata_write_addr/_data store address / data
//   idata_read_addr        load address
//   id_rs1, id_rs2         source registers of the instruction in ID
//   wb_reg_write_*         registered write-back address / enable / data
//   busy                   memory clear in progress
//   load_use_stall         combinational load-use hazard flag
module mem_wb_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int REG_AW = 4,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [REG_AW-1:0] ireg_write_addr,
  input  logic              ireg_write_en,
  input  logic [DATA_W-1:0] ireg_read_data1,
  input  logic              imem_to_reg,
  input  logic              imem_write_en,
  input  logic [ADDR_W-1:0] idata_write_addr,
  input  logic [DATA_W-1:0] idata_write_data,
  input  logic [ADDR_W-1:0] idata_read_addr,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic [REG_AW-1:0] wb_reg_write_addr,
  output logic              wb_reg_write_en,
  output logic [DATA_W-1:0] wb_reg_write_data,
  output logic              busy,
  output logic              load_use_stall
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clear_ptr_q, clear_ptr_d;
  logic [REG_AW-1:0]   wb_addr_q, wb_addr_d;
  logic                wb_en_q, wb_en_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;

  logic [DATA_W-1:0]   mem_q [0:DEPTH-1];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   rdata;

  // Write-first read: a store to the same address in this cycle is visible.
  always_comb begin
    rdata = mem_q[idata_read_addr];
    if (imem_write_en && (idata_write_addr == idata_read_addr)) begin
      rdata = idata_write_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    wb_addr_d   = wb_addr_q;
    wb_en_d     = 1'b0;
    wb_data_d   = wb_data_q;
    mem_we      = 1'b0;
    mem_waddr   = idata_write_addr;
    mem_wdata   = idata_write_data;
    case (state_q)
      CLEAR: begin
        // The single write port is owned by the fill; pipeline inputs are ignored.
        mem_we      = 1'b1;
        mem_waddr   = clear_ptr_q;
        mem_wdata   = '0;
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (en) begin
          mem_we    = imem_write_en;
          wb_addr_d = ireg_write_addr;
          wb_en_d   = ireg_write_en;
          wb_data_d = imem_to_reg ? rdata : ireg_read_data1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clear_ptr_q <= '0;
      wb_addr_q   <= '0;
      wb_en_q     <= 1'b0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      wb_addr_q   <= wb_addr_d;
      wb_en_q     <= wb_en_d;
      wb_data_q   <= wb_data_d;
    end
  end

  // Memory has no reset; rst only blocks writes on its own edge.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign wb_reg_write_addr = wb_addr_q;
  assign wb_reg_write_en   = wb_en_q;
  assign wb_reg_write_data = wb_data_q;
  assign busy              = (state_q == CLEAR);
  assign load_use_stall    = (state_q == RUN) && imem_to_reg && ireg_write_en &&
                             ((ireg_write_addr == id_rs1) || (ireg_write_addr == id_rs2));

endmodule
